// File: rtl/dsc_pkg.sv
// Shared types and helpers for the DSC bitstream encoder.
// The bit-reversed B reference is selected by defining DSC_BITREV_REF_EN.
package dsc_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   localparam int DATA_WIDTH = 5;

   function automatic int unsigned stream_len(input int w);
      return 32'd1 << w;
   endfunction

   // Reverses the low w bits of x; bits above w come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] x, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < w) begin
            r = {r[30:0], x[i]};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dsc_ref_gen.sv
// Beat counter that supplies the comparator references for both streams.
// With DSC_BITREV_REF_EN defined, the B reference is the bit-reversed count.
module dsc_ref_gen
   import dsc_pkg::*;
#(
   parameter int W = DATA_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] ref_a,
   output logic [W-1:0] ref_b,
   output logic         last
);

   localparam logic [W-1:0] LAST_IDX = W'(stream_len(W) - 1);

   logic [W-1:0] count_reg;

   // Clear wins over advance so a capture always restarts at beat 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign ref_a = count_reg;
   assign last  = (count_reg == LAST_IDX);

`ifdef DSC_BITREV_REF_EN
   logic [31:0] rev_full;
   assign rev_full = bitrev(32'(count_reg), W);
   assign ref_b    = rev_full[W-1:0];
`else
   assign ref_b = count_reg;
`endif

endmodule

// File: rtl/dsc_bitstream_encoder.sv
// Handshaked SNG: captures an operand pair and emits two N-beat unipolar streams.
// Optional macro DSC_BITREV_REF_EN decorrelates stream B via a bit-reversed reference.
module dsc_bitstream_encoder
   import dsc_pkg::*;
#(
   parameter int DATA_WIDTH = dsc_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] bin_a,
   input  logic [DATA_WIDTH-1:0] bin_b,
   output logic                  stream_valid,
   input  logic                  stream_ready,
   output logic                  stream_a,
   output logic                  stream_b,
   output logic                  stream_last,
   output logic                  busy
);

   state_t                state_reg;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] ref_a;
   logic [DATA_WIDTH-1:0] ref_b;
   logic                  last;
   logic                  run;
   logic                  transfer;
   logic                  capture;

   assign run      = (state_reg == RUN);
   assign transfer = run & stream_ready;
   assign capture  = in_valid & in_ready;

   dsc_ref_gen #(.W(DATA_WIDTH)) u_ref_gen (
      .clk   (clk),
      .rst   (rst),
      .en    (transfer),
      .clr   (capture),
      .ref_a (ref_a),
      .ref_b (ref_b),
      .last  (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
      end else begin
         state_reg <= state_next;
         if (capture) begin
            a_q <= bin_a;
            b_q <= bin_b;
         end
      end
   end

   // in_ready opens on the last-beat transfer so consecutive frames abut.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            in_ready = transfer & last;
            if (transfer && last) begin
               state_next = in_valid ? RUN : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign stream_valid = run;
   assign busy         = run;
   assign stream_last  = run & last;
   assign stream_a     = run & (ref_a < a_q);
   assign stream_b     = run & (ref_b < b_q);

endmodule

// File: tb/tb_dsc_bitstream_encoder.sv
// Directed bench for dsc_bitstream_encoder (DATA_WIDTH=5, N=32).
module tb_dsc_bitstream_encoder;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] bin_a;
   logic [4:0] bin_b;
   logic       stream_valid;
   logic       stream_ready;
   logic       stream_a;
   logic       stream_b;
   logic       stream_last;
   logic       busy;

   int tests_run;
   int tests_failed;

   dsc_bitstream_encoder #(.DATA_WIDTH(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .bin_a        (bin_a),
      .bin_b        (bin_b),
      .stream_valid (stream_valid),
      .stream_ready (stream_ready),
      .stream_a     (stream_a),
      .stream_b     (stream_b),
      .stream_last  (stream_last),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic start_frame(input logic [4:0] a, input logic [4:0] b);
      @(negedge clk);
      in_valid     = 1'b1;
      bin_a        = a;
      bin_b        = b;
      stream_ready = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL capture_ready a=%0d: in_ready=%b expected 1", a, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      bin_a    = ~a;
      bin_b    = ~b;
      tests_run++;
      if (stream_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL first_beat_latency a=%0d: stream_valid=%b expected 1", a, stream_valid);
      end
      $display("[TB] capture a=%0d b=%0d", a, b);
   endtask

   task automatic collect(input int stall_beat, input int stall_cycles,
                          output logic [31:0] sa, output logic [31:0] sb,
                          output logic [31:0] sl, output int beats, output int hold_bad);
      int cyc;
      int stalls;
      logic [3:0] snap;
      logic [3:0] cur;
      cyc = 0; stalls = 0; beats = 0; hold_bad = 0;
      sa = '0; sb = '0; sl = '0; snap = '0;
      while (beats < 32 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (beats == stall_beat && stalls < stall_cycles) begin
            stream_ready = 1'b0;
            stalls++;
         end else begin
            stream_ready = 1'b1;
         end
         #1;
         cur = {stream_valid, stream_a, stream_b, stream_last};
         if (!stream_ready) begin
            if (stalls == 1) snap = cur;
            else if (cur !== snap) hold_bad++;
         end else if (stream_valid === 1'b1) begin
            if (stall_cycles > 0 && beats == stall_beat && cur !== snap) hold_bad++;
            sa[beats] = stream_a;
            sb[beats] = stream_b;
            sl[beats] = stream_last;
            beats++;
         end
      end
      stream_ready = 1'b1;
      tests_run++;
      if (cyc >= 200) begin
         tests_failed++;
         $display("FAIL collect_timeout: beats=%0d expected 32", beats);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; stream_ready = 1'b1; bin_a = '0; bin_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({stream_valid, busy, stream_last, stream_a, stream_b} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: v/busy/last/a/b=%b expected 00000",
                  {stream_valid, busy, stream_last, stream_a, stream_b});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (stream_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL idle_after_reset: stream_valid=%b in_ready=%b expected 0/1", stream_valid, in_ready);
      end
      $display("[TB] reset checked");
   endtask

   task automatic test_zero();
      logic [31:0] sa, sb, sl;
      int beats, hb;
      start_frame(5'd0, 5'd0);
      collect(-1, 0, sa, sb, sl, beats, hb);
      tests_run++;
      if (beats != 32 || sa !== 32'h0 || sb !== 32'h0) begin
         tests_failed++;
         $display("FAIL zero_streams: beats=%0d a=%h b=%h expected 32/0/0", beats, sa, sb);
      end
      tests_run++;
      if (sl !== 32'h8000_0000) begin
         tests_failed++;
         $display("FAIL zero_last: last=%h expected 80000000", sl);
      end
      @(posedge clk); #1;
      tests_run++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || stream_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL zero_return_idle: busy=%b in_ready=%b valid=%b expected 0/1/0", busy, in_ready, stream_valid);
      end
      $display("[TB] frame a=0 b=0 a_bits=%h last=%h", sa, sl);
   endtask

   task automatic test_thermometer();
      logic [31:0] sa, sb, sl;
      int beats, hb;
      start_frame(5'd12, 5'd31);
      collect(-1, 0, sa, sb, sl, beats, hb);
      tests_run++;
      if (sa !== 32'h0000_0FFF) begin
         tests_failed++;
         $display("FAIL thermo_a: got %h expected 00000fff", sa);
      end
      tests_run++;
      if (sb !== 32'h7FFF_FFFF) begin
         tests_failed++;
         $display("FAIL thermo_b: got %h expected 7fffffff", sb);
      end
      $display("[TB] frame a=12 b=31 a_bits=%h b_bits=%h", sa, sb);
   endtask

   task automatic test_equal_operands();
      logic [31:0] sa, sb, sl, exp_b;
      int beats, hb;
`ifdef DSC_BITREV_REF_EN
      exp_b = 32'h1515_1515;
`else
      exp_b = 32'h0000_0FFF;
`endif
      start_frame(5'd12, 5'd12);
      collect(-1, 0, sa, sb, sl, beats, hb);
      tests_run++;
      if (sa !== 32'h0000_0FFF) begin
         tests_failed++;
         $display("FAIL equal_a: got %h expected 00000fff", sa);
      end
      tests_run++;
      if (sb !== exp_b) begin
         tests_failed++;
         $display("FAIL equal_b_pattern: got %h expected %h", sb, exp_b);
      end
      $display("[TB] frame a=12 b=12 a_bits=%h b_bits=%h", sa, sb);
   endtask

   task automatic test_backpressure();
      logic [31:0] sa, sb, sl;
      int beats, hb;
      start_frame(5'd20, 5'd0);
      collect(5, 3, sa, sb, sl, beats, hb);
      tests_run++;
      if (hb != 0) begin
         tests_failed++;
         $display("FAIL stall_hold: %0d changed samples expected 0", hb);
      end
      tests_run++;
      if (beats != 32 || sa !== 32'h000F_FFFF || sl !== 32'h8000_0000) begin
         tests_failed++;
         $display("FAIL stall_frame: beats=%0d a=%h last=%h expected 32/000fffff/80000000", beats, sa, sl);
      end
      $display("[TB] frame a=20 stalled at beat 5 a_bits=%h", sa);
   endtask

   task automatic test_back_to_back();
      logic [4:0] pa [3];
      logic [4:0] pb [3];
      int ones_a [3];
      int ones_b [3];
      int beats_f [3];
      int captured, frame, gaps, ready_bad, cyc;
      bit started;
      pa = '{5'd3, 5'd31, 5'd17};
      pb = '{5'd7, 5'd0, 5'd17};
      ones_a = '{0, 0, 0}; ones_b = '{0, 0, 0}; beats_f = '{0, 0, 0};
      captured = 0; frame = 0; gaps = 0; ready_bad = 0; cyc = 0; started = 0;
      while (frame < 3 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (captured < 3) begin
            in_valid = 1'b1; bin_a = pa[captured]; bin_b = pb[captured];
         end else begin
            in_valid = 1'b0;
         end
         stream_ready = 1'b1;
         #1;
         if (started) begin
            if (stream_valid !== 1'b1) gaps++;
            else begin
               beats_f[frame]++;
               ones_a[frame] += int'(stream_a);
               ones_b[frame] += int'(stream_b);
               if (in_ready !== stream_last) ready_bad++;
               if (stream_last) frame++;
            end
         end
         if (in_valid && in_ready) begin
            captured++;
            started = 1;
         end
      end
      in_valid = 1'b0;
      tests_run++;
      if (cyc >= 300 || captured != 3) begin
         tests_failed++;
         $display("FAIL b2b_progress: frames=%0d captures=%0d expected 3/3", frame, captured);
      end
      tests_run++;
      if (gaps != 0 || ready_bad != 0) begin
         tests_failed++;
         $display("FAIL b2b_abut: gaps=%0d ready_mismatches=%0d expected 0/0", gaps, ready_bad);
      end
      for (int f = 0; f < 3; f++) begin
         tests_run++;
         if (beats_f[f] != 32 || ones_a[f] != int'(pa[f]) || ones_b[f] != int'(pb[f])) begin
            tests_failed++;
            $display("FAIL b2b_frame%0d: beats=%0d ones_a=%0d ones_b=%0d expected 32/%0d/%0d",
                     f, beats_f[f], ones_a[f], ones_b[f], pa[f], pb[f]);
         end
         $display("[TB] b2b frame %0d ones_a=%0d ones_b=%0d", f, ones_a[f], ones_b[f]);
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] sa, sb, sl, exp_b;
      int beats, hb;
`ifdef DSC_BITREV_REF_EN
      exp_b = 32'h0101_0111;
`else
      exp_b = 32'h0000_001F;
`endif
      @(posedge clk);
      start_frame(5'd31, 5'd31);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if ({stream_valid, busy, stream_last, stream_a, stream_b} !== 5'b0) begin
         tests_failed++;
         $display("FAIL midframe_reset: v/busy/last/a/b=%b expected 00000",
                  {stream_valid, busy, stream_last, stream_a, stream_b});
      end
      @(negedge clk);
      rst = 1'b0;
      start_frame(5'd5, 5'd5);
      collect(-1, 0, sa, sb, sl, beats, hb);
      tests_run++;
      if (beats != 32 || sa !== 32'h0000_001F || sb !== exp_b || sl !== 32'h8000_0000) begin
         tests_failed++;
         $display("FAIL fresh_frame: beats=%0d a=%h b=%h last=%h expected 32/0000001f/%h/80000000",
                  beats, sa, sb, sl, exp_b);
      end
      $display("[TB] reset mid-frame then a=5 b=5 a_bits=%h b_bits=%h", sa, sb);
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_zero();
      test_thermometer();
      test_equal_operands();
      test_backpressure();
      test_back_to_back();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dsc_bitstream_encoder.md
Name: dsc_bitstream_encoder

Overview:
- Transmit-side stochastic number generator (SNG) for the DSC datapath. It converts a pair of captured binary operands into deterministic unipolar bitstreams of length 2^DATA_WIDTH.
- Streams carry valid/ready/last framing so the downstream accumulator or stoch2bin stage can consume them under backpressure.
- Sits between the pixel/operand source and any serial DSC kernel. It replaces the free-running counter + comparator front end with a handshaked, frame-delimited producer.

Parameters:
- DATA_WIDTH, 5, operand width. Stream length is N = 2^DATA_WIDTH beats.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  encoder accepts operands this cycle.
- bin_a  input  DATA_WIDTH  operand A, unsigned.
- bin_b  input  DATA_WIDTH  operand B, unsigned.
- stream_valid  output  1  stream beat valid.
- stream_ready  input  1  downstream accepts the beat.
- stream_a  output  1  bitstream bit for A.
- stream_b  output  1  bitstream bit for B.
- stream_last  output  1  final beat of the frame (beat index N-1).
- busy  output  1  frame in progress.

Behaviour:
- States: IDLE, RUN.
- Reset values: state=IDLE, ref counter=0, captured regs=0, stream_valid=0, stream_last=0, busy=0, stream_a=0, stream_b=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture bin_a/bin_b into a_q/b_q, clear counter to 0, go to RUN.
  - First beat appears the next cycle (latency 1).
- RUN:
  - stream_valid=1, busy=1.
  - stream_a = (ref_a < a_q); stream_b = (ref_b < b_q). Comparisons are unsigned.
  - ref_a = counter. ref_b = counter, or counter bit-reversed when the optional feature is compiled in.
- Beat transfer occurs on stream_valid&stream_ready only. When stream_ready=0 the counter and all outputs hold stable, and the beat must not change.
- stream_last = (counter == N-1) in RUN.
- On the transfer of the last beat:
  - in_ready=1 in that same cycle, so back-to-back frames run with no bubble.
  - If in_valid: capture the new operands, counter wraps to 0, stay in RUN.
  - Else: go to IDLE.
- in_ready has a combinational path from stream_ready in RUN only. Stream outputs derive from registers only.
- Operands are sampled only at capture. Changes to bin_a/bin_b during RUN are ignored.
- Operand value v yields exactly v ones per N-beat frame. v=0 gives an all-zero stream. v=N-1 gives N-1 ones; full scale 1.0 is not representable.
- Counter wraps at N-1 to 0 only via frame restart. It never free-runs in IDLE.
- Asynchronous reset mid-frame aborts the frame immediately: all outputs go to their reset values and no partial last is emitted.

Optional Feature:
- Macro: DSC_BITREV_REF_EN.
- Defined: ref_b is the bit-reversed counter, giving low-discrepancy, decorrelated B streams. Ones in B are spread across the frame while the count still equals b_q.
- Undefined: ref_b = counter. Both streams are thermometer-coded (ones first) and fully correlated, so XOR computes |a-b|.

Decomposition:
- Package dsc_pkg holds:
  - state enum {IDLE, RUN};
  - default DATA_WIDTH=5;
  - function stream_len(w) = 1<<w;
  - function bitrev(x, w).
- One sub-module, dsc_ref_gen: counter with enable, synchronous clear, last flag, and a bit-reversed output tap when DSC_BITREV_REF_EN is defined.
- The FSM, capture registers and comparators live in the top module.

Test Plan (DATA_WIDTH=5, N=32):
- Capture a=0, b=0, stream_ready=1 → 32 beats, all zero; stream_last high only on beat 31; return to IDLE; in_ready=1 the next cycle.
- Capture a=12, b=31, macro undefined → stream_a = 12 ones then 20 zeros. stream_b = 31 ones then a single zero on beat 31.
- Capture a=b=12, macro defined → 12 ones on each stream. stream_b ones fall at the bit-reversed indices {0,16,8,24,4,20,12,28,2,18,10,26}.
- a=20, stream_ready held low for 3 cycles at beat 5 → beat 5 value is stable for 4 cycles; the frame still totals 32 transfers with 20 ones.
- in_valid held high with a sequence of 3 operand pairs → frames abut with no idle cycle; in_ready pulses on each last-beat transfer; ones count per frame matches each operand.
- Assert rst at beat 10 of a frame, then release → stream_valid=0 and busy=0 immediately; the next capture starts a fresh frame at beat 0.
